edge_event_arbiter: RTL and testbench
=====================================

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NCH, default 4, number of level-input channels (2..8).
REQ-002 Parameter IDW, default $clog2(NCH), width of the event channel-ID output.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 level  input  NCH  per-channel level signals, synchronous to clk.
REQ-006 evt_valid  output  1  event present on evt_id.
REQ-007 evt_ready  input  1  consumer accepts the event when evt_valid&&evt_ready at a rising edge.
REQ-008 evt_id  output  IDW  channel index of the presented rising-edge event.
REQ-009 ovf  output  NCH  sticky per-channel dropped-event flags.
REQ-010 ovf_clr  input  1  one-cycle pulse that clears all ovf bits.
REQ-011 state_o  output  2*NCH  concatenated per-channel detector states, channel 0 in bits [1:0].

Function
REQ-012 Each channel SHALL contain a Moore edge detector with states ZERO=0, EDGE=1, ONE=2; encoding 3 is unreachable and SHALL return to ZERO.
REQ-013 Detector transitions: ZERO + level=1 -> EDGE; EDGE + level=1 -> ONE; EDGE + level=0 -> ZERO; ONE + level=0 -> ZERO; all others hold.
REQ-014 Internal tick[ch] SHALL be 1 exactly while the detector is in EDGE, giving a one-cycle tick per rising edge.
REQ-015 pend[ch] SHALL be set at the rising edge following a cycle with tick[ch]=1.
REQ-016 Output register: when empty (evt_valid=0) or handshaking this cycle, the block SHALL load the next pending channel, set evt_valid=1, and clear that channel's pend bit in the same edge.
REQ-017 Selection SHALL be round-robin: search starts at (last granted ID + 1) mod NCH and wraps; the first search after reset starts at channel 0.
REQ-018 evt_id SHALL be held stable while evt_valid=1 and evt_ready=0.
REQ-019 On handshake with no pend bit set, evt_valid SHALL drop to 0 at that edge.
REQ-020 Handshake and reload in the same cycle SHALL provide back-to-back events, one per cycle, with no bubble.
REQ-021 Latency: level rising sampled at edge k -> tick after edge k -> pend at edge k+1 -> evt_valid at edge k+2, when the output is idle.
REQ-022 A tick for the channel currently shown on evt_id SHALL set pend normally; no drop occurs.
REQ-023 Drop condition: tick[ch]=1 while pend[ch]=1 and pend[ch] is not cleared by a load at that edge. The event SHALL be discarded and ovf[ch] set.
REQ-024 ovf_clr SHALL clear all ovf bits. A drop in the same cycle as ovf_clr SHALL win, leaving that bit set.

Reset
REQ-025 Asserting reset SHALL immediately force all detectors to ZERO, pend=0, evt_valid=0, evt_id=0, ovf=0, state_o=0, and the round-robin pointer to its post-reset value, independent of clk.
REQ-026 A reset asserted while an event is presented SHALL discard that event and all pending events. No event is replayed after reset.
REQ-027 After reset deasserts, a channel whose level is already high SHALL produce one event via ZERO -> EDGE.

Configuration
REQ-028 Macro EDGE_ARB_DROP_CNT_EN defined: add output drop_cnt [7:0], a saturating total of dropped events across all channels. It increments by the number of channels dropping in that cycle, saturates at 255, clears on reset and on ovf_clr, and the increment wins over ovf_clr in the same cycle.
REQ-029 Macro EDGE_ARB_DROP_CNT_EN undefined: the drop_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-030 Single edge: reset, evt_ready=1, level[2] 0->1 at edge k -> evt_valid=1 with evt_id=2 at edge k+2 for exactly 1 cycle, and state_o[5:4] follows 1 then 2.
REQ-031 Round-robin: evt_ready=0, rising edges on channels 0, 1 and 3 in the same cycle, then evt_ready=1 -> evt_id sequence 0, 1, 3 on consecutive cycles with no bubble.
REQ-032 Backpressure: evt_ready=0 for 5 cycles with evt_id=1 presented -> evt_id and evt_valid stay unchanged for all 5 cycles.
REQ-033 Overflow: evt_ready=0; channel 0 event presented, then two more rising edges on channel 0 -> pend[0] is set and the second tick drops, ovf=4'b0001, drop_cnt=1 if EDGE_ARB_DROP_CNT_EN is defined; ovf_clr pulse -> ovf=0.
REQ-034 Reset mid-operation: assert reset asynchronously (between edges) with evt_valid=1 and two channels pending -> evt_valid=0 immediately; after release no event appears while level is held low.
REQ-035 Level held high for 20 cycles -> exactly one event; level toggling every cycle -> EDGE/ZERO alternation with one event per rising edge.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// -----------------------------------------------------------------------------
// edge_event_arbiter
//
// Purpose: detects rising edges on NCH level inputs. Each edge becomes a
// pending event. Pending events are presented one at a time on a
// valid/ready output, in round-robin order. An edge that arrives while its
// channel already has an unconsumed pending event is discarded, and the
// channel's sticky overflow flag is set.
//
// Optional feature (macro EDGE_ARB_DROP_CNT_EN): adds the drop_cnt output,
// a saturating 8-bit count of all discarded events.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high reset
//   level      in   NCH per-channel level inputs, synchronous to clk
//   evt_valid  out  an event is presented on evt_id
//   evt_ready  in   consumer accepts the event (evt_valid && evt_ready)
//   evt_id     out  channel index of the presented event
//   ovf        out  sticky per-channel dropped-event flags
//   ovf_clr    in   one-cycle pulse that clears ovf (and drop_cnt)
//   state_o    out  per-channel detector states, channel 0 in [1:0]
//   drop_cnt   out  [EDGE_ARB_DROP_CNT_EN only] saturating drop total
//
// Detector states:
//   state | meaning
//   ZERO  | level seen low (or post-reset)
//   EDGE  | first cycle high; emits a one-cycle tick
//   ONE   | level still high; no further ticks
// -----------------------------------------------------------------------------
module edge_event_arbiter #(
    parameter int NCH = 4,
    parameter int IDW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDW-1:0]   evt_id,
    output logic [NCH-1:0]   ovf,
    input  logic             ovf_clr,
    output logic [2*NCH-1:0] state_o
`ifdef EDGE_ARB_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        EDGE = 2'd1,
        ONE  = 2'd2
    } det_state_t;

    logic [NCH-1:0]   w_tick;
    logic [NCH-1:0]   r_pend;
    logic             r_evt_valid;
    logic [IDW-1:0]   r_evt_id;
    logic [IDW-1:0]   r_ptr;
    logic [NCH-1:0]   r_ovf;

    logic             w_load;
    logic [2*NCH-1:0] w_pend2;
    logic [NCH-1:0]   w_rot;
    logic             w_found;
    logic [IDW-1:0]   w_off;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_sel;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [NCH-1:0]   w_clr;
    logic [NCH-1:0]   w_drop;

    // Per-channel Moore edge detectors.
    for (genvar g = 0; g < NCH; g++) begin : g_det
        det_state_t r_state;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state <= ZERO;
            end else begin
                case (r_state)
                    ZERO:    if (level[g]) r_state <= EDGE;
                    EDGE:    r_state <= level[g] ? ONE : ZERO;
                    ONE:     if (!level[g]) r_state <= ZERO;
                    default: r_state <= ZERO;
                endcase
            end
        end

        assign w_tick[g]          = (r_state == EDGE);
        assign state_o[2*g +: 2]  = r_state;
    end

    // The output register may take a new event when it is empty or the
    // current one is being accepted at this edge.
    assign w_load = !r_evt_valid || evt_ready;

    // Round-robin search: rotate pend so the pointer channel sits at bit 0,
    // find the lowest set bit, then map the offset back to a channel index.
    always_comb begin
        w_pend2 = {r_pend, r_pend} >> r_ptr;
        w_rot   = w_pend2[NCH-1:0];
        w_found = 1'b0;
        w_off   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_found = 1'b1;
                w_off   = IDW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(NCH)) begin
            w_sum = w_sum - (IDW+1)'(NCH);
        end
        w_sel     = w_sum[IDW-1:0];
        w_ptr_nxt = (w_sel == IDW'(NCH - 1)) ? '0 : w_sel + IDW'(1);
    end

    assign w_clr  = (w_load && w_found) ? (NCH'(1) << w_sel) : '0;
    // A tick is lost only if its pend bit survives this edge.
    assign w_drop = w_tick & r_pend & ~w_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend      <= '0;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_ptr       <= '0;
            r_ovf       <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_tick;
            // Clear first, then OR in drops, so a drop in the clear cycle wins.
            r_ovf  <= (ovf_clr ? '0 : r_ovf) | w_drop;
            if (w_load) begin
                r_evt_valid <= w_found;
                if (w_found) begin
                    r_evt_id <= w_sel;
                    r_ptr    <= w_ptr_nxt;
                end
            end
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign ovf       = r_ovf;

`ifdef EDGE_ARB_DROP_CNT_EN
    logic [7:0] r_drop_cnt;
    logic [3:0] w_drop_num;
    logic [8:0] w_cnt_sum;

    always_comb begin
        w_drop_num = '0;
        for (int i = 0; i < NCH; i++) begin
            w_drop_num = w_drop_num + {3'b000, w_drop[i]};
        end
        w_cnt_sum = {1'b0, (ovf_clr ? 8'd0 : r_drop_cnt)} + {5'b00000, w_drop_num};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

    localparam int NCH = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [NCH-1:0]   level;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDW-1:0]   evt_id;
    logic [NCH-1:0]   ovf;
    logic             ovf_clr;
    logic [2*NCH-1:0] state_o;
`ifdef EDGE_ARB_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [IDW-1:0] exp_q[$];

    edge_event_arbiter #(.NCH(NCH), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .state_o   (state_o)
`ifdef EDGE_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted event must match the next expected ID.
    always @(negedge clk) begin
        logic [IDW-1:0] exp_id;
        if (!reset && evt_valid === 1'b1 && evt_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected got id %0d expected no event", evt_id);
            end else begin
                exp_id = exp_q.pop_front();
                if (evt_id !== exp_id) begin
                    n_errors++;
                    $display("FAIL sb_id got %0d expected %0d", evt_id, exp_id);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        level     = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_out got valid %0b id %0d expected 0 0", evt_valid, evt_id);
        end
        n_checks++;
        if (ovf !== 4'b0000 || state_o !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_state got ovf %b state %h expected 0000 00", ovf, state_o);
        end
`ifdef EDGE_ARB_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_drop_cnt got %0d expected 0", drop_cnt);
        end
`endif
        apply_reset();
    endtask

    task automatic test_single_edge();
        apply_reset();
        evt_ready = 1'b1;
        level = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        n_checks++;
        if (state_o[5:4] !== 2'd1 || evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_k got state %0d valid %0b expected 1 0", state_o[5:4], evt_valid);
        end
        step();
        n_checks++;
        if (state_o[5:4] !== 2'd2 || evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_k1 got state %0d valid %0b expected 2 0", state_o[5:4], evt_valid);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            n_errors++;
            $display("FAIL single_k2 got valid %0b id %0d expected 1 2", evt_valid, evt_id);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_k3 got valid %0b expected 0", evt_valid);
        end
        level = '0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        level = 4'b1011;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        step();
        step();
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            n_errors++;
            $display("FAIL rr_first got valid %0b id %0d expected 1 0", evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            n_errors++;
            $display("FAIL rr_second got valid %0b id %0d expected 1 1", evt_valid, evt_id);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            n_errors++;
            $display("FAIL rr_third got valid %0b id %0d expected 1 3", evt_valid, evt_id);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rr_empty got valid %0b expected 0", evt_valid);
        end
        level = '0;
        evt_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        level = 4'b0010;
        step();
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
                n_errors++;
                $display("FAIL bp_hold cycle %0d got valid %0b id %0d expected 1 1", i, evt_valid, evt_id);
            end
        end
        exp_q.push_back(2'd1);
        evt_ready = 1'b1;
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_release got valid %0b expected 0", evt_valid);
        end
        level = '0;
        evt_ready = 1'b0;
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            level[0] = (i % 2 == 0);
            step();
            if (i == 4) begin
                n_checks++;
                if (ovf !== 4'b0000) begin
                    n_errors++;
                    $display("FAIL ovf_early got %b expected 0000", ovf);
                end
            end
        end
        n_checks++;
        if (ovf !== 4'b0001 || evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            n_errors++;
            $display("FAIL ovf_drop got ovf %b valid %0b id %0d expected 0001 1 0", ovf, evt_valid, evt_id);
        end
`ifdef EDGE_ARB_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL drop_cnt_one got %0d expected 1", drop_cnt);
        end
`endif
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 4'b0000) begin
            n_errors++;
            $display("FAIL ovf_clear got %b expected 0000", ovf);
        end
`ifdef EDGE_ARB_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL drop_cnt_clear got %0d expected 0", drop_cnt);
        end
`endif
        // A drop in the same cycle as ovf_clr keeps its bit set.
        level[0] = 1'b1;
        step();
        level[0] = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 4'b0001) begin
            n_errors++;
            $display("FAIL ovf_drop_wins got %b expected 0001", ovf);
        end
`ifdef EDGE_ARB_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL drop_cnt_wins got %0d expected 1", drop_cnt);
        end
`endif
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        evt_ready = 1'b1;
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            n_errors++;
            $display("FAIL ovf_drain got valid %0b id %0d expected 1 0", evt_valid, evt_id);
        end
        step();
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_drain_end got valid %0b expected 0", evt_valid);
        end
        evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cnt;
        apply_reset();
        level = 4'b0111;
        step();
        level = '0;
        step();
        step();
        n_checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
            n_errors++;
            $display("FAIL mid_pre got valid %0b id %0d expected 1 0", evt_valid, evt_id);
        end
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0 || state_o !== 8'h00 || ovf !== 4'b0000) begin
            n_errors++;
            $display("FAIL mid_async got valid %0b id %0d state %h ovf %b expected 0 0 00 0000",
                     evt_valid, evt_id, state_o, ovf);
        end
        step();
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (evt_valid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_errors++;
            $display("FAIL mid_no_replay got %0d valid cycles expected 0", cnt);
        end
        // Level already high when reset releases gives exactly one event.
        reset = 1'b1;
        level = 4'b1000;
        step();
        exp_q.push_back(2'd3);
        evt_ready = 1'b1;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (evt_valid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 1) begin
            n_errors++;
            $display("FAIL high_at_release got %0d events expected 1", cnt);
        end
        level = '0;
        evt_ready = 1'b0;
    endtask

    task automatic test_level_patterns();
        int cnt;
        apply_reset();
        evt_ready = 1'b1;
        level = 4'b0010;
        exp_q.push_back(2'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (evt_valid === 1'b1) cnt++;
        end
        level = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (evt_valid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 1) begin
            n_errors++;
            $display("FAIL hold_high got %0d events expected 1", cnt);
        end
        for (int i = 0; i < 10; i++) exp_q.push_back(2'd2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            logic [1:0] exp_st;
            level[2] = (i % 2 == 0);
            exp_st = (i % 2 == 0) ? 2'd1 : 2'd0;
            step();
            n_checks++;
            if (state_o[5:4] !== exp_st) begin
                n_errors++;
                $display("FAIL toggle_state step %0d got %0d expected %0d", i, state_o[5:4], exp_st);
            end
            if (evt_valid === 1'b1) cnt++;
        end
        level = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (evt_valid === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== 10) begin
            n_errors++;
            $display("FAIL toggle_events got %0d expected 10", cnt);
        end
        evt_ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        level     = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        test_reset();
        test_single_edge();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_level_patterns();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
